// File: rtl/exmem_pkg.sv
// Shared widths, bubble instruction, occupancy encoding and entry layout for the
// EX->MEM elastic stage.
package exmem_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OP_W    = 16;
    localparam int DEF_RES_W   = 32;

    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 16'h0000;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_OP_W-1:0]    op1;
        logic [DEF_RES_W-1:0]   result;
    } entry_t;

endpackage

// File: rtl/exmem_elastic_reg_pipe_skid_slot.sv
// One entry register of the EX->MEM stage: load enable plus synchronous clear,
// clear winning over load.
module pipe_skid_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Entry storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (clr) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/exmem_elastic_reg.sv
// EX->MEM valid/ready pipeline register with a 2-entry skid buffer and branch flush.
// Optional hazard-unit forwarding ports are built when EXMEM_FWD_EN is defined.
module exmem_elastic_reg
    import exmem_pkg::*;
#(
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter int                 OP_W      = DEF_OP_W,
    parameter int                 RES_W     = DEF_RES_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int                 RD_LSB    = 8,
    parameter int                 RD_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [OP_W-1:0]    op1_in,
    input  logic [RES_W-1:0]   alu_result_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [OP_W-1:0]    op1_out,
    output logic [RES_W-1:0]   alu_result_out,
    output logic [RES_W-1:0]   btb_target
`ifdef EXMEM_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RD_W-1:0]    fwd_rd,
    output logic [RES_W-1:0]   fwd_data
`endif
);

    localparam int ENTRY_W = INSTR_W + OP_W + RES_W;

    // An out-of-range destination field simply elaborates this marker block.
    if (RD_LSB + RD_W > INSTR_W) begin : g_rd_field_out_of_range
    end

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic               in_ready_r;
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic               occupied_s;
    logic               main_load_s;
    logic               skid_load_s;
    logic               slots_clr_s;
    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] main_d_s;
    logic [ENTRY_W-1:0] main_q_s;
    logic [ENTRY_W-1:0] skid_q_s;

    assign in_entry_s = {instr_in, op1_in, alu_result_in};
    assign occupied_s = (state_r != ST_EMPTY);
    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = occupied_s && out_ready;

    // Occupancy transitions and slot load selection; flush overrides everything
    always_comb begin
        state_nxt_s = state_r;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        slots_clr_s = 1'b0;
        main_d_s    = in_entry_s;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            slots_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                    end else if (in_xfer_s) begin
                        state_nxt_s = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the skid entry can move up
                    if (out_xfer_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                        main_d_s    = skid_q_s;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    slots_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state and the registered ready derived from the next occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != ST_TWO);
        end
    end

    pipe_skid_slot #(.W(ENTRY_W)) u_main_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (slots_clr_s),
        .load (main_load_s),
        .d    (main_d_s),
        .q    (main_q_s)
    );

    pipe_skid_slot #(.W(ENTRY_W)) u_skid_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (slots_clr_s),
        .load (skid_load_s),
        .d    (in_entry_s),
        .q    (skid_q_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = occupied_s;

    // Head entry toward MEM, shown as a bubble while the stage is empty
    always_comb begin
        if (occupied_s) begin
            instr_out      = main_q_s[ENTRY_W-1 -: INSTR_W];
            op1_out        = main_q_s[RES_W +: OP_W];
            alu_result_out = main_q_s[RES_W-1:0];
        end else begin
            instr_out      = NOP_INSTR;
            op1_out        = '0;
            alu_result_out = '0;
        end
    end

    assign btb_target = alu_result_out;

`ifdef EXMEM_FWD_EN
    // Forwarding view of the head entry, all-zero while empty
    always_comb begin
        if (occupied_s) begin
            fwd_valid = 1'b1;
            fwd_rd    = main_q_s[RES_W + OP_W + RD_LSB +: RD_W];
            fwd_data  = main_q_s[RES_W-1:0];
        end else begin
            fwd_valid = 1'b0;
            fwd_rd    = '0;
            fwd_data  = '0;
        end
    end
`endif

endmodule

// File: tb/tb_exmem_elastic_reg.sv
// Scoreboard bench for exmem_elastic_reg: a queue model of the stage contents is
// updated at each clock edge by the driver and checked by a negedge monitor.
module tb_exmem_elastic_reg;
    import exmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr_in;
    logic [15:0] op1_in;
    logic [31:0] alu_result_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr_out;
    logic [15:0] op1_out;
    logic [31:0] alu_result_out;
    logic [31:0] btb_target;
`ifdef EXMEM_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int     n_chk  = 0;
    int     n_fail = 0;
    entry_t exp_q[$];

    exmem_elastic_reg dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr_in       (instr_in),
        .op1_in         (op1_in),
        .alu_result_in  (alu_result_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr_out      (instr_out),
        .op1_out        (op1_out),
        .alu_result_out (alu_result_out),
        .btb_target     (btb_target)
`ifdef EXMEM_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the presented head against the model, pop on handshake
    always @(negedge clk) begin
        automatic bit     have = (exp_q.size() > 0);
        automatic entry_t e    = '0;
        if (have) e = exp_q[0];
        chk("out_valid", {31'd0, out_valid}, {31'd0, have});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2)});
        chk("instr_out", {16'd0, instr_out}, {16'd0, (have ? e.instr : 16'h0000)});
        chk("op1_out", {16'd0, op1_out}, {16'd0, e.op1});
        chk("alu_result_out", alu_result_out, e.result);
        chk("btb_target", btb_target, e.result);
`ifdef EXMEM_FWD_EN
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, have});
        chk("fwd_rd", {28'd0, fwd_rd}, {28'd0, e.instr[11:8]});
        chk("fwd_data", fwd_data, e.result);
`endif
        if (have && out_ready) void'(exp_q.pop_front());
    end

    // One cycle of stimulus; the model decides acceptance from start-of-cycle occupancy
    task automatic step(input bit iv, input logic [15:0] ins, input logic [15:0] o1,
                        input logic [31:0] res, input bit ordy, input bit fl);
        automatic int     occ = exp_q.size();
        automatic entry_t e;
        in_valid      = iv;
        instr_in      = ins;
        op1_in        = o1;
        alu_result_in = res;
        out_ready     = ordy;
        flush         = fl;
        e.instr  = ins;
        e.op1    = o1;
        e.result = res;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (iv && occ < 2) exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 16'h0000, 32'h0, 1'b1, 1'b0);
        chk("drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; instr_in = 16'h0000; op1_in = 16'h0000; alu_result_in = 32'h0;
        out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Empty stage with out_ready high stays a bubble
        for (int i = 0; i < 3; i++) step(1'b0, 16'h1234, 16'h5678, 32'hFFFF, 1'b1, 1'b0);

        // Fill to TWO then reset mid-stream
        step(1'b1, 16'h0101, 16'h0001, 32'h1, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 16'h0002, 32'h2, 1'b0, 1'b0);
        in_valid = 1'b1;
        do_reset();

        // Streaming at full rate
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'hA100 + 16'(i), 16'h0A00 + 16'(i), 32'h10 + 32'(i), 1'b1, 1'b0);
        drain();

        // Backpressure with a held third offer
        step(1'b1, 16'h00AA, 16'h0011, 32'hAA, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 16'h0022, 32'hBB, 1'b0, 1'b0);
        step(1'b1, 16'h00CC, 16'h0033, 32'hCC, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h00CC, 16'h0033, 32'hCC, 1'b1, 1'b0);
        drain();

        // Flush while full with a same-cycle offer, then normal traffic
        step(1'b1, 16'h0011, 16'h0001, 32'h11, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 16'h0002, 32'h22, 1'b0, 1'b0);
        step(1'b1, 16'h00DD, 16'h0003, 32'hDD, 1'b1, 1'b1);
        step(1'b1, 16'h00EE, 16'h0004, 32'hEE, 1'b1, 1'b0);
        drain();

        // Forwarding field extraction
        step(1'b1, 16'h0A00, 16'h0000, 32'h55, 1'b0, 1'b0);
        drain();

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
